// File: rtl/alu_pmu_pkg.sv
// Shared definitions for the ALU power-management sequencer: state encoding,
// default dwell times and the dwell-counter width helper.
package alu_pmu_pkg;

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_SAVE      = 3'd2,
    ST_ISO       = 3'd3,
    ST_OFF       = 3'd4,
    ST_RAMP      = 3'd5,
    ST_RESTORE   = 3'd6
  } pmu_state_e;

  localparam int unsigned ISO_DLY_DEF  = 2;
  localparam int unsigned RAMP_DLY_DEF = 4;

  // Counter must hold the larger of the two dwell times.
  function automatic int unsigned dly_cnt_w(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/pmu_dly_cnt.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module pmu_dly_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_pmu_ctrl.sv
// ALU power-domain sequencer: orders save, isolation, power-off, ramp, restore
// and de-isolation. All outputs are registered copies decoded from the next state.
module alu_pmu_ctrl
  import alu_pmu_pkg::*;
#(
  parameter int unsigned ISO_DLY  = ISO_DLY_DEF,
  parameter int unsigned RAMP_DLY = RAMP_DLY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic [2:0] pmu_state
);

  localparam int unsigned CW = dly_cnt_w(ISO_DLY, RAMP_DLY);
  // Loaded with DLY-1 so the state is held for exactly DLY cycles.
  localparam logic [CW-1:0] ISO_LOAD  = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] RAMP_LOAD = CW'(RAMP_DLY - 1);

  pmu_state_e    state_q, state_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_done;

  logic pwr_q, iso_q, save_q, restore_q, sleep_ack_q, wake_ack_q;

  pmu_dly_cnt #(.W(CW)) u_dly_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_ON: begin
        if (sleep_req && !wake_req) begin
          state_d = alu_busy ? ST_WAIT_IDLE : ST_SAVE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!sleep_req) begin
          state_d = ST_ON;
        end else if (!alu_busy) begin
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        state_d  = ST_ISO;
        cnt_load = 1'b1;
        cnt_val  = ISO_LOAD;
      end
      ST_ISO: begin
        if (cnt_done) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (wake_req && !sleep_req) begin
          state_d  = ST_RAMP;
          cnt_load = 1'b1;
          cnt_val  = RAMP_LOAD;
        end
      end
      ST_RAMP: begin
        if (cnt_done) begin
          state_d = ST_RESTORE;
        end
      end
      ST_RESTORE: state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ON;
      pwr_q       <= 1'b1;
      iso_q       <= 1'b0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      sleep_ack_q <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= (state_d != ST_OFF);
      iso_q       <= (state_d == ST_ISO) || (state_d == ST_OFF) ||
                     (state_d == ST_RAMP) || (state_d == ST_RESTORE);
      save_q      <= (state_d == ST_SAVE);
      restore_q   <= (state_d == ST_RESTORE);
      sleep_ack_q <= (state_d == ST_OFF) && (state_q != ST_OFF);
      wake_ack_q  <= (state_d == ST_ON) && (state_q == ST_RESTORE);
    end
  end

  assign alu_pwr_en = pwr_q;
  assign iso_en     = iso_q;
  assign save       = save_q;
  assign restore    = restore_q;
  assign sleep_ack  = sleep_ack_q;
  assign wake_ack   = wake_ack_q;
  assign pmu_state  = state_q;

  // Electrical safety properties of the power-control pins.
  a_iso_when_off: assert property (@(posedge clk) disable iff (!rst_n) !(!pwr_q && !iso_q));
  a_save_xor_rst: assert property (@(posedge clk) disable iff (!rst_n) !(save_q && restore_q));
  a_save_powered: assert property (@(posedge clk) disable iff (!rst_n) !(save_q && (!pwr_q || iso_q)));

endmodule

// File: doc/alu_pmu_ctrl.md
# alu_pmu_ctrl

Power-management sequencer that drives the ALU power-domain control pins `alu_pwr_en`, `iso_en`, `save` and `restore` into the ALU/always-on wrapper. It sits in the always-on domain and accepts level sleep/wake requests from the system. It orders save, isolation, power-off, ramp, restore and de-isolation so the retained result is captured before power drops and replayed before isolation lifts.

## Interface
- `ISO_DLY`, default 2: cycles isolation is held before `alu_pwr_en` drops (≥1).
- `RAMP_DLY`, default 4: cycles after `alu_pwr_en` rises before `restore` (≥1).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sleep_req`  in  1  level; request ALU power-down.
- `wake_req`  in  1  level; request ALU power-up.
- `alu_busy`  in  1  ALU `busy`; power-down must not start while high.
- `alu_pwr_en`  out  1  ALU domain power switch enable.
- `iso_en`  out  1  output isolation enable.
- `save`  out  1  one-cycle retention capture strobe.
- `restore`  out  1  one-cycle retention replay strobe.
- `sleep_ack`  out  1  one-cycle pulse on entry to OFF.
- `wake_ack`  out  1  one-cycle pulse on entry to ON from RESTORE.
- `pmu_state`  out  3  current state encoding (debug).

## Operation
- States: ON, WAIT_IDLE, SAVE, ISO, OFF, RAMP, RESTORE.
- ON: pwr=1, iso=0. If `sleep_req & !wake_req`: go to SAVE when `alu_busy`=0, else WAIT_IDLE. Both requests high: stay ON.
- WAIT_IDLE: pwr=1, iso=0. `sleep_req` low → ON (abort). `alu_busy` low → SAVE.
- SAVE: `save`=1, pwr=1, iso=0; one cycle → ISO. Committed: requests are ignored from here until OFF.
- ISO: iso=1, pwr=1; `ISO_DLY` cycles → OFF.
- OFF: iso=1, pwr=0; `sleep_ack` on the first cycle only. `wake_req & !sleep_req` → RAMP. Otherwise stay.
- RAMP: pwr=1, iso=1; `RAMP_DLY` cycles → RESTORE. Requests are ignored.
- RESTORE: `restore`=1, pwr=1, iso=1; one cycle → ON. `wake_ack` on the first ON cycle.
- `iso_en` is never 0 while `alu_pwr_en` is 0. `save` and `restore` are never both high. `save` is only asserted with pwr=1 and iso=0.
- The dwell counter is loaded on state entry and counts down. Its width is `$clog2(max(ISO_DLY,RAMP_DLY)+1)`. It has no wrap; it saturates at 0.

## Timing
- Reset (async assert, sync deassert handled upstream): state ON. `alu_pwr_en`=1; `iso_en`, `save`, `restore`, `sleep_ack` and `wake_ack` = 0; `pmu_state`=ON; counter=0.
- All outputs are registered and reflect the current state; there is no combinational input→output path.
- Power-down latency is measured from the edge that samples `sleep_req`=1 with `alu_busy`=0 (edge 0):
  - `save` is high in cycle 1.
  - `iso_en` rises in cycle 2.
  - `alu_pwr_en` falls and `sleep_ack` pulses in cycle 2+`ISO_DLY`.
- Power-up latency is measured from the edge that samples `wake_req` in OFF (edge N):
  - `alu_pwr_en` rises in cycle N+1.
  - `restore` is high in cycle N+1+`RAMP_DLY`.
  - `iso_en` falls and `wake_ack` pulses in cycle N+2+`RAMP_DLY`.
- `rst_n` asserted mid-sequence (any state): all outputs take their reset values immediately, with pwr=1 and iso=0. The retained value is not restored.

## Structure
- Shared package `alu_pmu_pkg`: state enum (3-bit encoding) and default `ISO_DLY`/`RAMP_DLY` constants, reused by the bench and wrapper.
- Sub-module `pmu_dly_cnt`: loadable down-counter with a `done` flag (counter == 0), parameterized width. Everything else lives in the single FSM module.

## Test plan
- Clean sleep/wake, ISO_DLY=2, RAMP_DLY=4:
  - `sleep_req` at edge 0 → `save` in cycle 1; `iso_en`=1 from cycle 2; `alu_pwr_en`=0 and `sleep_ack` in cycle 4.
  - `wake_req` at edge 20 → pwr=1 in cycle 21; `restore` in cycle 25; iso=0 and `wake_ack` in cycle 26.
- Busy hold: `alu_busy`=1 for 5 cycles after `sleep_req` → `pmu_state`=WAIT_IDLE for 5 cycles; `save` one cycle after `alu_busy` falls.
- Abort: `sleep_req` drops while in WAIT_IDLE → back to ON. `save`, `iso_en` and `sleep_ack` never assert.
- Simultaneous requests:
  - Both high in ON → stays ON indefinitely.
  - Both high in OFF → stays OFF.
  - `wake_req` pulsed during ISO → ignored; sequence reaches OFF.
- Reset mid-RAMP: `rst_n` low in cycle 2 of RAMP → same cycle pwr=1, iso=0, restore=0, state ON. No `wake_ack`.
- Invariant checkers run throughout: never (pwr=0 & iso=0); never (save & restore); `save` only with pwr=1 and iso=0. Exercise with end-to-end integration: the ALU result before sleep equals `result` after wake.
